hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_pkg.sv | 19 +
 rtl/sat_counter.sv | 32 +++
 rtl/hazard_ctrl.sv | 143 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared types and constants for the pipeline hazard controller.
//   state_t         : controller FSM states (RUN, MDU_WAIT)
//   MDU_CYCLES_DEF  : default number of ID-stage stall cycles for mult/div
//   REG_ZERO        : architectural register zero (never a real hazard source)
// -----------------------------------------------------------------------------
package hazard_pkg;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MDU_WAIT = 1'b1
    } state_t;

    localparam int MDU_CYCLES_DEF = 4;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter used for hazard statistics. Increments by one on each
// rising clock edge where inc is high and holds at all-ones instead of wrapping.
// Ports:
//   clk   : clock
//   rst   : asynchronous, active-low reset (clears the count)
//   inc   : increment enable
//   count : current count value
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg <= '0;
        end else if (inc && (count_reg != '1)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Pipeline hazard controller: detects load-use hazards, sequences multi-cycle
// mult/div stalls and flushes IF/ID + ID/EX on taken branches.
// Ports:
//   clk, rst           : clock, asynchronous active-low reset
//   id_rs, id_rt       : source register fields of the instruction in ID
//   id_use_rs/rt       : ID instruction actually reads rs / rt
//   id_mdu             : ID instruction is mult/div
//   ex_memr, ex_rt     : EX instruction is a load, and its destination
//   ex_branch_taken    : branch in EX resolved taken
//   pc_wr, if_id_wr    : PC / IF-ID write enables   (combinational)
//   if_id_flush        : zero IF/ID                 (combinational)
//   id_ex_stall        : insert bubble into ID/EX   (combinational)
//   id_ex_flush        : flush ID/EX                (combinational)
//   mdu_busy           : registered, high while in MDU_WAIT
//   stall_cnt          : saturating count of cycles with id_ex_stall=1
//   flush_cnt          : saturating count of cycles with id_ex_flush=1
// -----------------------------------------------------------------------------
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MDU_CYCLES = MDU_CYCLES_DEF,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_mdu,
    input  logic             ex_memr,
    input  logic [4:0]       ex_rt,
    input  logic             ex_branch_taken,
    output logic             pc_wr,
    output logic             if_id_wr,
    output logic             if_id_flush,
    output logic             id_ex_stall,
    output logic             id_ex_flush,
    output logic             mdu_busy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [7:0] MCNT_LOAD = 8'(MDU_CYCLES - 1);

    state_t     state_reg, state_next;
    logic [7:0] mcnt_reg, mcnt_next;
    logic       grant_reg, grant_next;
    logic       mdu_busy_reg;
    logic       lu;

    // Register zero is hardwired, so a load targeting it never creates a hazard.
    assign lu = ex_memr && (ex_rt != REG_ZERO) &&
                ((id_use_rs && (id_rs == ex_rt)) || (id_use_rt && (id_rt == ex_rt)));

    always_comb begin
        pc_wr       = 1'b1;
        if_id_wr    = 1'b1;
        if_id_flush = 1'b0;
        id_ex_stall = 1'b0;
        id_ex_flush = 1'b0;
        state_next  = state_reg;
        mcnt_next   = mcnt_reg;
        grant_next  = grant_reg;

        if (!rst) begin
            // Hold defaults while in reset; state is being cleared anyway.
            state_next = RUN;
        end else if (ex_branch_taken) begin
            // Branch wins over everything, including an in-flight MDU wait.
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            state_next  = RUN;
            mcnt_next   = 8'd0;
            grant_next  = 1'b0;
        end else if (state_reg == MDU_WAIT) begin
            // Already stalling, so a load-use hazard here needs nothing extra.
            pc_wr       = 1'b0;
            if_id_wr    = 1'b0;
            id_ex_stall = 1'b1;
            mcnt_next   = mcnt_reg - 8'd1;
            if (mcnt_reg == 8'd1) begin
                state_next = RUN;
                grant_next = 1'b1;
            end
        end else if (lu) begin
            pc_wr       = 1'b0;
            if_id_wr    = 1'b0;
            id_ex_stall = 1'b1;
        end else if (grant_reg) begin
            // The mult/div still sitting in ID has served its stall; let it go.
            grant_next = 1'b0;
        end else if (id_mdu) begin
            // First stall cycle is spent here in RUN, the rest in MDU_WAIT.
            pc_wr       = 1'b0;
            if_id_wr    = 1'b0;
            id_ex_stall = 1'b1;
            mcnt_next   = MCNT_LOAD;
            state_next  = MDU_WAIT;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= RUN;
            mcnt_reg     <= 8'd0;
            grant_reg    <= 1'b0;
            mdu_busy_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            mcnt_reg     <= mcnt_next;
            grant_reg    <= grant_next;
            mdu_busy_reg <= (state_next == MDU_WAIT);
        end
    end

    assign mdu_busy = mdu_busy_reg;

    // Statistics counters: index 0 counts stall cycles, index 1 flush cycles.
    logic [1:0]       cnt_inc;
    logic [CNT_W-1:0] cnt_val [2];

    assign cnt_inc = {id_ex_flush, id_ex_stall};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_stat
            sat_counter #(
                .WIDTH(CNT_W)
            ) u_cnt (
                .clk  (clk),
                .rst  (rst),
                .inc  (cnt_inc[gi]),
                .count(cnt_val[gi])
            );
        end
    endgenerate

    assign stall_cnt = cnt_val[0];
    assign flush_cnt = cnt_val[1];

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
// Directed testbench for hazard_ctrl. A default instance (MDU_CYCLES=4,
// CNT_W=16) exercises the hazard logic; a second instance with CNT_W=4 checks
// counter saturation. Combinational outputs are packed as
// {pc_wr, if_id_wr, if_id_flush, id_ex_stall, id_ex_flush}.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

    localparam logic [4:0] O_DEF   = 5'b11000;
    localparam logic [4:0] O_STALL = 5'b00010;
    localparam logic [4:0] O_FLUSH = 5'b11101;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs, id_rt, ex_rt;
    logic        id_use_rs, id_use_rt, id_mdu, ex_memr, ex_branch_taken;
    logic        pc_wr, if_id_wr, if_id_flush, id_ex_stall, id_ex_flush, mdu_busy;
    logic [15:0] stall_cnt, flush_cnt;

    logic [4:0]  w_id_rs, w_id_rt, w_ex_rt;
    logic        w_id_use_rs, w_id_use_rt, w_id_mdu, w_ex_memr, w_ex_branch_taken;
    logic        w_pc_wr, w_if_id_wr, w_if_id_flush, w_id_ex_stall, w_id_ex_flush, w_mdu_busy;
    logic [3:0]  w_stall_cnt, w_flush_cnt;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.MDU_CYCLES(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_mdu(id_mdu), .ex_memr(ex_memr), .ex_rt(ex_rt),
        .ex_branch_taken(ex_branch_taken),
        .pc_wr(pc_wr), .if_id_wr(if_id_wr), .if_id_flush(if_id_flush),
        .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush),
        .mdu_busy(mdu_busy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    hazard_ctrl #(.MDU_CYCLES(4), .CNT_W(4)) dut_w (
        .clk(clk), .rst(rst),
        .id_rs(w_id_rs), .id_rt(w_id_rt), .id_use_rs(w_id_use_rs), .id_use_rt(w_id_use_rt),
        .id_mdu(w_id_mdu), .ex_memr(w_ex_memr), .ex_rt(w_ex_rt),
        .ex_branch_taken(w_ex_branch_taken),
        .pc_wr(w_pc_wr), .if_id_wr(w_if_id_wr), .if_id_flush(w_if_id_flush),
        .id_ex_stall(w_id_ex_stall), .id_ex_flush(w_id_ex_flush),
        .mdu_busy(w_mdu_busy), .stall_cnt(w_stall_cnt), .flush_cnt(w_flush_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
            $display("check %-16s obs=%0h exp=%0h ok", tag, obs, exp);
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {27'd0, pc_wr, if_id_wr, if_id_flush, id_ex_stall, id_ex_flush};
    endfunction

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
        id_use_rs = 1'b0; id_use_rt = 1'b0; id_mdu = 1'b0;
        ex_memr = 1'b0; ex_branch_taken = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        w_id_rs = 5'd0; w_id_rt = 5'd0; w_ex_rt = 5'd0;
        w_id_use_rs = 1'b0; w_id_use_rt = 1'b0; w_id_mdu = 1'b0;
        w_ex_memr = 1'b0; w_ex_branch_taken = 1'b0;

        // Reset state, with a load-use pattern applied to prove outputs stay default.
        tick();
        ex_memr = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; id_use_rs = 1'b1;
        #1;
        check("rst_outs", outs(), {27'd0, O_DEF});
        check("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
        check("rst_flush_cnt", {16'd0, flush_cnt}, 32'd0);
        check("rst_busy", {31'd0, mdu_busy}, 32'd0);
        tick();
        idle_inputs();
        rst = 1'b1;
        #1;
        check("idle_outs", outs(), {27'd0, O_DEF});

        // Load-use via rs.
        ex_memr = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; id_use_rs = 1'b1;
        #1;
        check("lu_rs_outs", outs(), {27'd0, O_STALL});
        check("lu_rs_cnt_pre", {16'd0, stall_cnt}, 32'd0);
        tick();
        check("lu_rs_cnt_post", {16'd0, stall_cnt}, 32'd1);

        // Same but destination is r0: no hazard.
        ex_rt = 5'd0; id_rs = 5'd0;
        #1;
        check("lu_r0_outs", outs(), {27'd0, O_DEF});
        tick();
        check("lu_r0_cnt", {16'd0, stall_cnt}, 32'd1);

        // Load-use via rt.
        idle_inputs();
        ex_memr = 1'b1; ex_rt = 5'd5; id_rt = 5'd5; id_use_rt = 1'b1;
        #1;
        check("lu_rt_outs", outs(), {27'd0, O_STALL});
        tick();
        check("lu_rt_cnt", {16'd0, stall_cnt}, 32'd2);

        // Matching rt field that is not read: no hazard.
        id_use_rt = 1'b0;
        #1;
        check("lu_nouse_outs", outs(), {27'd0, O_DEF});
        // Not a load: no hazard.
        id_use_rt = 1'b1; ex_memr = 1'b0;
        #1;
        check("lu_nomem_outs", outs(), {27'd0, O_DEF});
        tick();
        idle_inputs();

        // Mult/div held: 4 stall cycles, busy for 3, fifth passes.
        id_mdu = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("mdu_outs_%0d", i), outs(),
                  {27'd0, (i < 4) ? O_STALL : O_DEF});
            check($sformatf("mdu_busy_%0d", i), {31'd0, mdu_busy},
                  {31'd0, (i >= 1 && i <= 3)});
            tick();
        end
        id_mdu = 1'b0;
        #1;
        check("mdu_stall_cnt", {16'd0, stall_cnt}, 32'd6);
        check("mdu_busy_after", {31'd0, mdu_busy}, 32'd0);
        check("mdu_after_outs", outs(), {27'd0, O_DEF});

        // Branch coincident with load-use.
        ex_memr = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; id_use_rs = 1'b1;
        ex_branch_taken = 1'b1;
        #1;
        check("br_lu_outs", outs(), {27'd0, O_FLUSH});
        tick();
        check("br_lu_flush_cnt", {16'd0, flush_cnt}, 32'd1);
        check("br_lu_stall_cnt", {16'd0, stall_cnt}, 32'd6);
        idle_inputs();

        // Branch on the 2nd MDU_WAIT cycle.
        id_mdu = 1'b1;
        tick();                         // RUN stall cycle done
        tick();                         // 1st MDU_WAIT cycle done
        check("br_mdu_busy_pre", {31'd0, mdu_busy}, 32'd1);
        id_mdu = 1'b0; ex_branch_taken = 1'b1;
        #1;
        check("br_mdu_outs", outs(), {27'd0, O_FLUSH});
        tick();
        ex_branch_taken = 1'b0;
        #1;
        check("br_mdu_busy_post", {31'd0, mdu_busy}, 32'd0);
        check("br_mdu_run_outs", outs(), {27'd0, O_DEF});
        check("br_mdu_flush_cnt", {16'd0, flush_cnt}, 32'd2);
        check("br_mdu_stall_cnt", {16'd0, stall_cnt}, 32'd8);

        // Reset asserted mid MDU_WAIT.
        id_mdu = 1'b1;
        tick();
        tick();
        check("rst_mdu_busy_pre", {31'd0, mdu_busy}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("rst_mdu_busy", {31'd0, mdu_busy}, 32'd0);
        check("rst_mdu_stall_cnt", {16'd0, stall_cnt}, 32'd0);
        check("rst_mdu_flush_cnt", {16'd0, flush_cnt}, 32'd0);
        check("rst_mdu_outs", outs(), {27'd0, O_DEF});
        tick();
        id_mdu = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_rel_outs", outs(), {27'd0, O_DEF});
        tick();
        check("rst_rel_busy", {31'd0, mdu_busy}, 32'd0);

        // Saturation on the 4-bit instance: 20 consecutive stall cycles.
        w_ex_memr = 1'b1; w_ex_rt = 5'd3; w_id_rs = 5'd3; w_id_use_rs = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 13) check("sat_cnt_14", {28'd0, w_stall_cnt}, 32'd14);
        end
        check("sat_cnt_20", {28'd0, w_stall_cnt}, 32'd15);
        check("sat_outs", {27'd0, w_pc_wr, w_if_id_wr, w_if_id_flush, w_id_ex_stall, w_id_ex_flush},
              {27'd0, O_STALL});
        w_ex_memr = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
